// File: rtl/mcs_bridge_pkg.sv
// Shared types and constants for the MicroBlaze MCS to FPro MMIO bridge.
package mcs_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_STB,
    WR_STB,
    RD_WAIT,
    DONE,
    ERR
  } bridge_state_t;

  localparam int          VIDEO_SEL_BIT = 23;
  localparam logic [3:0]  FULL_WORD_BE  = 4'hF;
  localparam int          MMIO_ADDR_W   = 21;

endpackage

// File: rtl/mcs_fpro_bridge.sv
// MCS IO bus to FPro MMIO bridge: window decode, one-shot mmio strobes, delayed read capture.
// Optional saturating error counter enabled by defining MCS_BRIDGE_ERR_CNT_EN.
module mcs_fpro_bridge
  import mcs_bridge_pkg::*;
#(
  parameter logic [31:0] BRIDGE_BASE = 32'hC000_0000,
  parameter int unsigned RD_LAT      = 0,
  parameter logic [31:0] MISS_DATA   = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   io_addr_strobe,
  input  logic                   io_read_strobe,
  input  logic                   io_write_strobe,
  input  logic [31:0]            io_address,
  input  logic [3:0]             io_byte_enable,
  input  logic [31:0]            io_write_data,
  output logic [31:0]            io_read_data,
  output logic                   io_ready,
  output logic                   mmio_cs,
  output logic                   mmio_wr,
  output logic                   mmio_rd,
  output logic [MMIO_ADDR_W-1:0] mmio_addr,
  output logic [31:0]            mmio_wr_data,
  input  logic [31:0]            mmio_rd_data,
  output logic                   bridge_err
`ifdef MCS_BRIDGE_ERR_CNT_EN
  ,
  input  logic                   err_clr,
  output logic [15:0]            err_cnt
`endif
);

  bridge_state_t          state, state_nxt;
  logic [2:0]             lat_cnt, lat_cnt_nxt;
  logic                   capture;
  logic                   hit;
  logic                   viol_q;
  logic [MMIO_ADDR_W-1:0] addr_q;
  logic [31:0]            wdata_q;
  logic [31:0]            rdata_q;
  logic                   unused_addr_lsb;

  assign unused_addr_lsb = ^io_address[1:0];

  // Bit 23 selects the video window, which this bridge does not serve
  assign hit = (io_address[31:24] == BRIDGE_BASE[31:24]) && !io_address[VIDEO_SEL_BIT];

  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        if (io_addr_strobe) begin
          if (hit && io_read_strobe && !io_write_strobe)
            state_nxt = RD_STB;
          else if (hit && io_write_strobe && !io_read_strobe && io_byte_enable == FULL_WORD_BE)
            state_nxt = WR_STB;
          else
            state_nxt = ERR;
        end
      end
      WR_STB: state_nxt = DONE;
      RD_STB: begin
        if (RD_LAT == 0) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else begin
          lat_cnt_nxt = 3'(RD_LAT);
          state_nxt   = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_cnt == 3'd1) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else begin
          lat_cnt_nxt = lat_cnt - 3'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      lat_cnt <= 3'd0;
      viol_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
      // A strobe during ERR is folded into the error pulse already in progress
      viol_q  <= io_addr_strobe && (state != IDLE) && (state != ERR);
      if (state == IDLE && io_addr_strobe) begin
        addr_q  <= io_address[VIDEO_SEL_BIT-1:2];
        wdata_q <= io_write_data;
      end
      if (capture)
        rdata_q <= mmio_rd_data;
      else if (state == WR_STB)
        rdata_q <= '0;
    end
  end

  assign mmio_cs      = (state == RD_STB) || (state == WR_STB);
  assign mmio_rd      = (state == RD_STB);
  assign mmio_wr      = (state == WR_STB);
  assign mmio_addr    = addr_q;
  assign mmio_wr_data = wdata_q;
  assign io_ready     = (state == DONE) || (state == ERR);
  assign io_read_data = (state == ERR) ? MISS_DATA : rdata_q;
  assign bridge_err   = (state == ERR) || viol_q;

`ifdef MCS_BRIDGE_ERR_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err_cnt <= 16'd0;
    else if (err_clr)
      err_cnt <= 16'd0;
    else if (bridge_err && err_cnt != 16'hFFFF)
      err_cnt <= err_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mcs_fpro_bridge.sv
// Bench for mcs_fpro_bridge: two instances (read latency 0 and 3), vector table, corner sequences, random traffic.
module tb_mcs_fpro_bridge;

  localparam logic [31:0] MISS = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n  [2];
  logic        stb    [2];
  logic        rd_s   [2];
  logic        wr_s   [2];
  logic [31:0] addr   [2];
  logic [3:0]  be     [2];
  logic [31:0] wd     [2];
  logic [31:0] rdd    [2];
  logic [31:0] rdata  [2];
  logic        ready  [2];
  logic        cs     [2];
  logic        mwr    [2];
  logic        mrd    [2];
  logic [20:0] maddr  [2];
  logic [31:0] mwd    [2];
  logic        err    [2];
`ifdef MCS_BRIDGE_ERR_CNT_EN
  logic        eclr   [2];
  logic [15:0] ecnt   [2];
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mcs_fpro_bridge #(.BRIDGE_BASE(32'hC000_0000), .RD_LAT(0), .MISS_DATA(MISS)) u0 (
    .clk(clk), .reset(rst_n[0]), .io_addr_strobe(stb[0]), .io_read_strobe(rd_s[0]),
    .io_write_strobe(wr_s[0]), .io_address(addr[0]), .io_byte_enable(be[0]),
    .io_write_data(wd[0]), .io_read_data(rdata[0]), .io_ready(ready[0]), .mmio_cs(cs[0]),
    .mmio_wr(mwr[0]), .mmio_rd(mrd[0]), .mmio_addr(maddr[0]), .mmio_wr_data(mwd[0]),
    .mmio_rd_data(rdd[0]), .bridge_err(err[0])
`ifdef MCS_BRIDGE_ERR_CNT_EN
    , .err_clr(eclr[0]), .err_cnt(ecnt[0])
`endif
  );

  mcs_fpro_bridge #(.BRIDGE_BASE(32'hC000_0000), .RD_LAT(3), .MISS_DATA(MISS)) u1 (
    .clk(clk), .reset(rst_n[1]), .io_addr_strobe(stb[1]), .io_read_strobe(rd_s[1]),
    .io_write_strobe(wr_s[1]), .io_address(addr[1]), .io_byte_enable(be[1]),
    .io_write_data(wd[1]), .io_read_data(rdata[1]), .io_ready(ready[1]), .mmio_cs(cs[1]),
    .mmio_wr(mwr[1]), .mmio_rd(mrd[1]), .mmio_addr(maddr[1]), .mmio_wr_data(mwd[1]),
    .mmio_rd_data(rdd[1]), .bridge_err(err[1])
`ifdef MCS_BRIDGE_ERR_CNT_EN
    , .err_clr(eclr[1]), .err_cnt(ecnt[1])
`endif
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [3:0]  b;
    logic [31:0] w;
    logic [31:0] rv;
    int          lat0;
    bit          e;
    logic [31:0] data;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: classify a request purely from the address window and strobe/byte-lane rules
  function automatic void model(input bit rd, input bit wr, input logic [31:0] a,
                                input logic [3:0] b, input logic [31:0] rv, input int lat,
                                output int elat, output bit eerr, output logic [31:0] edata);
    bit hit;
    hit = (a[31:24] == 8'hC0) && !a[23];
    if (hit && rd && !wr) begin
      elat = 2 + lat; eerr = 1'b0; edata = rv;
    end else if (hit && wr && !rd && b == 4'hF) begin
      elat = 2; eerr = 1'b0; edata = 32'h0;
    end else begin
      elat = 1; eerr = 1'b1; edata = MISS;
    end
  endfunction

  // Called on a falling edge; that cycle is cycle 0 and the request is sampled at its end
  task automatic do_txn(input int d, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] w, input logic [31:0] rv,
                        input int extra_at, input int rst_at, input int elat, input bit eerr,
                        input logic [31:0] edata, input string nm);
    bit erd, ewr;
    logic z;
    int n, rdy_idx, rdy_n, rd_n, wr_n, cs_n, err_n, exp_err_n;
    logic [31:0] rdy_data, a_stb, w_stb;
    erd = rd && !eerr;
    ewr = wr && !eerr;
    n = (rst_at != 0) ? rst_at + 12 : elat + 1;
    rdy_idx = -1; rdy_n = 0; rd_n = 0; wr_n = 0; cs_n = 0; err_n = 0;
    rdy_data = '0; a_stb = '0; w_stb = '0;
    stb[d] = 1'b1; rd_s[d] = rd; wr_s[d] = wr; addr[d] = a; be[d] = b; wd[d] = w; rdd[d] = rv;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (ready[d]) begin
        rdy_n++;
        if (rdy_idx < 0) begin rdy_idx = k; rdy_data = rdata[d]; end
      end
      if (mrd[d]) rd_n++;
      if (mwr[d]) wr_n++;
      if (cs[d]) begin cs_n++; a_stb = 32'(maddr[d]); w_stb = mwd[d]; end
      if (err[d]) err_n++;
      stb[d] = (k == extra_at);
      if (k == rst_at) begin
        rst_n[d] = 1'b0;
        #1;
        z = ready[d] | cs[d] | mrd[d] | mwr[d] | err[d] | (|maddr[d]) | (|mwd[d]) | (|rdata[d]);
        chk($sformatf("%s reset_outputs_zero", nm), 32'(z), 32'h0);
      end
      if (rst_at != 0 && k == rst_at + 2) rst_n[d] = 1'b1;
    end
    stb[d] = 1'b0; rd_s[d] = 1'b0; wr_s[d] = 1'b0;
    if (rst_at != 0) begin
      chk($sformatf("%s no_ready_after_reset", nm), 32'(rdy_n), 32'h0);
      chk($sformatf("%s no_err_after_reset", nm), 32'(err_n), 32'h0);
      chk($sformatf("%s single_rd_strobe", nm), 32'(rd_n), 32'h1);
    end else begin
      exp_err_n = int'(eerr) + ((extra_at != 0 && !eerr) ? 1 : 0);
      chk($sformatf("%s ready_latency", nm), 32'(rdy_idx), 32'(elat));
      chk($sformatf("%s ready_count", nm), 32'(rdy_n), 32'h1);
      chk($sformatf("%s read_data", nm), rdy_data, edata);
      chk($sformatf("%s rd_strobes", nm), 32'(rd_n), 32'(erd));
      chk($sformatf("%s wr_strobes", nm), 32'(wr_n), 32'(ewr));
      chk($sformatf("%s cs_cycles", nm), 32'(cs_n), 32'(erd | ewr));
      chk($sformatf("%s err_pulses", nm), 32'(err_n), 32'(exp_err_n));
      if (erd || ewr) chk($sformatf("%s mmio_addr", nm), a_stb, 32'(a[22:2]));
      if (ewr) chk($sformatf("%s mmio_wr_data", nm), w_stb, w);
    end
  endtask

  vec_t vt[9];

  initial begin
    int elat;
    bit eerr;
    logic [31:0] edata, ra, rw, rv;
    logic [3:0] rb;
    bit rrd, rwr;
    int t;
`ifdef MCS_BRIDGE_ERR_CNT_EN
    logic [15:0] before;
`endif

    vt[0] = '{0, 1, 32'hC000_0008, 4'hF, 32'h1234_5678, 32'h0,         2, 0, 32'h0};
    vt[1] = '{1, 0, 32'hC000_0010, 4'h0, 32'h0,         32'hA5A5_0001, 2, 0, 32'hA5A5_0001};
    vt[2] = '{1, 0, 32'hD000_0000, 4'hF, 32'h0,         32'h1111_2222, 1, 1, MISS};
    vt[3] = '{1, 0, 32'hC080_0000, 4'hF, 32'h0,         32'h3333_4444, 1, 1, MISS};
    vt[4] = '{0, 1, 32'hC000_0004, 4'h3, 32'h5555_6666, 32'h0,         1, 1, MISS};
    vt[5] = '{1, 1, 32'hC000_0000, 4'hF, 32'h7777_8888, 32'h9999_AAAA, 1, 1, MISS};
    vt[6] = '{0, 1, 32'hC07F_FFFC, 4'hF, 32'hCAFE_F00D, 32'h0,         2, 0, 32'h0};
    vt[7] = '{1, 0, 32'hC07F_FFFC, 4'h5, 32'h0,         32'h0BAD_1DEA, 2, 0, 32'h0BAD_1DEA};
    vt[8] = '{1, 0, 32'hBF00_0000, 4'hF, 32'h0,         32'h0F0F_0F0F, 1, 1, MISS};

    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; stb[d] = 1'b0; rd_s[d] = 1'b0; wr_s[d] = 1'b0;
      addr[d] = '0; be[d] = '0; wd[d] = '0; rdd[d] = '0;
`ifdef MCS_BRIDGE_ERR_CNT_EN
      eclr[d] = 1'b0;
`endif
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset d%0d io_ready", d), 32'(ready[d]), 32'h0);
      chk($sformatf("reset d%0d io_read_data", d), rdata[d], 32'h0);
      chk($sformatf("reset d%0d mmio_cs", d), 32'(cs[d]), 32'h0);
      chk($sformatf("reset d%0d bridge_err", d), 32'(err[d]), 32'h0);
      chk($sformatf("reset d%0d mmio_addr", d), 32'(maddr[d]), 32'h0);
`ifdef MCS_BRIDGE_ERR_CNT_EN
      chk($sformatf("reset d%0d err_cnt", d), 32'(ecnt[d]), 32'h0);
`endif
      rst_n[d] = 1'b1;
    end
    @(negedge clk);

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 9; i++)
        do_txn(d, vt[i].rd, vt[i].wr, vt[i].a, vt[i].b, vt[i].w, vt[i].rv, 0, 0,
               vt[i].lat0 + ((!vt[i].e && vt[i].rd) ? 3 * d : 0), vt[i].e, vt[i].data,
               $sformatf("vec%0d d%0d", i, d));

    // Second strobe during the read strobe cycle, then a request right after DONE
    do_txn(1, 1, 0, 32'hC000_0010, 4'hF, 32'h0, 32'hA5A5_0001, 1, 0, 5, 0, 32'hA5A5_0001, "viol_rdstb");
    do_txn(1, 1, 0, 32'hC000_0020, 4'hF, 32'h0, 32'h600D_0002, 0, 0, 5, 0, 32'h600D_0002, "done_plus1");
    // Strobe during DONE of a write, then strobe during ERR of a miss
    do_txn(0, 0, 1, 32'hC000_0100, 4'hF, 32'hFACE_0001, 32'h0, 2, 0, 2, 0, 32'h0, "viol_done");
    do_txn(0, 1, 0, 32'hD000_0000, 4'hF, 32'h0, 32'h0, 1, 0, 1, 1, MISS, "viol_err");
    // Reset asserted in the middle of the read wait, then a normal read
    do_txn(1, 1, 0, 32'hC000_0040, 4'hF, 32'h0, 32'h1357_9BDF, 0, 3, 5, 0, 32'h1357_9BDF, "rst_rdwait");
    do_txn(1, 1, 0, 32'hC000_0044, 4'hF, 32'h0, 32'h2468_ACE0, 0, 0, 5, 0, 32'h2468_ACE0, "after_rst");

`ifdef MCS_BRIDGE_ERR_CNT_EN
    before = ecnt[0];
    do_txn(0, 0, 1, 32'hC000_0004, 4'h3, 32'h1, 32'h0, 0, 0, 1, 1, MISS, "cnt_partial");
    chk("err_cnt_increment", 32'(ecnt[0]), 32'(before + 16'd1));
    eclr[0] = 1'b1;
    @(negedge clk);
    eclr[0] = 1'b0;
    chk("err_cnt_clear", 32'(ecnt[0]), 32'h0);
`endif

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 40; i++) begin
        case ($urandom_range(0, 3))
          0:       ra = {8'hC0, 1'b1, 23'($urandom)};
          1:       ra = {8'($urandom_range(0, 255)), 24'($urandom)};
          default: ra = {8'hC0, 1'b0, 23'($urandom)};
        endcase
        t = $urandom_range(0, 4);
        rrd = (t <= 1) || (t == 4);
        rwr = (t == 2) || (t == 3) || (t == 4);
        rb = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
        rw = $urandom;
        rv = $urandom;
        model(rrd, rwr, ra, rb, rv, 3 * d, elat, eerr, edata);
        do_txn(d, rrd, rwr, ra, rb, rw, rv, 0, 0, elat, eerr, edata, $sformatf("rand%0d d%0d", i, d));
      end
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mcs_fpro_bridge.md
Name: mcs_fpro_bridge

Overview:
- Bridges the MicroBlaze MCS IO bus to the FPro MMIO bus that feeds mmio_sys_sampler; directly upstream of it.
- Decodes the MMIO window and registers each request.
- Issues exactly one single-cycle mmio_rd/mmio_wr strobe per accepted request.
- Captures read data after a configurable latency and returns io_ready/io_read_data to the processor.
- Flags protocol and decode errors.

Parameters:
- BRIDGE_BASE, 32'hC000_0000, base address of the FPro IO window; compare on io_address[31:24].
- RD_LAT, 0, extra wait cycles between the mmio_rd strobe and read-data capture (0..7).
- MISS_DATA, 32'h0000_0000, value returned on io_read_data for an error response.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- io_addr_strobe  in  1  MCS request valid
- io_read_strobe  in  1  MCS read request
- io_write_strobe  in  1  MCS write request
- io_address  in  32  MCS byte address
- io_byte_enable  in  4  MCS byte lanes
- io_write_data  in  32  MCS write data
- io_read_data  out  32  read data returned to MCS
- io_ready  out  1  single-cycle completion pulse
- mmio_cs  out  1  FPro chip select
- mmio_wr  out  1  FPro write strobe
- mmio_rd  out  1  FPro read strobe
- mmio_addr  out  21  FPro word address, io_address[22:2]
- mmio_wr_data  out  32  FPro write data
- mmio_rd_data  in  32  FPro read data from the MMIO subsystem
- bridge_err  out  1  single-cycle error pulse

Behaviour:
- Reset: asynchronous, active-low. While reset=0:
  - state is IDLE.
  - io_ready, io_read_data, mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data and bridge_err are all 0.
  - Any in-flight request is aborted; no io_ready is issued for it after reset releases.
- Hit rule: io_address[31:24]==BRIDGE_BASE[31:24] and io_address[23]==0. Bit 23 set is reserved for the video window and is treated as a miss.
- Request capture: a request is accepted only in IDLE with io_addr_strobe=1.
  - Address, write data, type and byte enables are registered at that clock edge (cycle T).
- State machine:
  - IDLE: on a hit read, go to RD_STB. On a hit full-word write (byte_enable==4'hF), go to WR_STB. On a miss, a partial write, or read and write strobes both set, go to ERR.
  - WR_STB (T+1): mmio_cs=1, mmio_wr=1, registered addr/data driven. Go to DONE.
  - RD_STB (T+1): mmio_cs=1, mmio_rd=1. If RD_LAT==0, capture mmio_rd_data at this edge and go to DONE; otherwise load the latency counter with RD_LAT and go to RD_WAIT.
  - RD_WAIT: the counter decrements each cycle; mmio_cs/mmio_rd are 0. When the counter reaches 1, capture mmio_rd_data and go to DONE.
  - DONE: io_ready=1 for exactly one cycle; io_read_data holds the captured data (reads) or 0 (writes). Go to IDLE.
  - ERR (T+1): io_ready=1, io_read_data=MISS_DATA, bridge_err=1; no mmio strobe. Go to IDLE.
- Latencies (strobe cycle to io_ready):
  - write: 2 cycles
  - read: 2+RD_LAT cycles
  - error: 1 cycle
- io_read_data is held from DONE until the next capture. It is valid only while io_ready=1.
- io_addr_strobe while not IDLE is a protocol violation:
  - the request is dropped and bridge_err pulses the next cycle;
  - the in-flight request completes normally;
  - if the violation coincides with ERR, bridge_err stays a single pulse.
- Back-to-back: a new strobe in the same cycle as io_ready is a violation, since state is DONE or ERR. A strobe one cycle later is accepted.
- Reads ignore io_byte_enable.

Optional Feature:
- Macro MCS_BRIDGE_ERR_CNT_EN.
- Defined:
  - adds output err_cnt[15:0], a saturating count of bridge_err pulses, stopping at 16'hFFFF;
  - adds input err_clr, a synchronous clear that takes priority over increment in the same cycle;
  - err_cnt resets to 0.
- Undefined: neither port exists, and there is no counter logic.

Decomposition:
- Package mcs_bridge_pkg holds:
  - typedef enum bridge_state_t {IDLE, RD_STB, WR_STB, RD_WAIT, DONE, ERR};
  - constant VIDEO_SEL_BIT=23;
  - constant FULL_WORD_BE=4'hF;
  - the localparam for the 21-bit MMIO address width.
- No sub-module; the latency counter is a 3-bit down-counter inside the FSM block.

Test Plan:
- Write 0xC000_0008, data 0x1234_5678, be=F → mmio_wr=1 with mmio_addr=21'h2 and wr_data 0x1234_5678 at T+1; io_ready at T+2; bridge_err stays 0.
- Read 0xC000_0010, RD_LAT=0, mmio_rd_data=0xA5A5_0001 → mmio_rd pulse at T+1, io_ready at T+2 with io_read_data=0xA5A5_0001. Repeat with RD_LAT=3 → io_ready at T+5; mmio_rd high for exactly one cycle.
- Read 0xD000_0000 (miss) and read 0xC080_0000 (video bit set) → io_ready at T+1, io_read_data=MISS_DATA, bridge_err=1, no mmio_cs.
- Write with be=4'h3 → no mmio_wr; io_ready and bridge_err at T+1. With MCS_BRIDGE_ERR_CNT_EN, err_cnt increments by 1.
- Second io_addr_strobe at T+1 of an in-flight read → first read completes with correct data; second is dropped; one bridge_err pulse. Strobe at DONE+1 is accepted normally.
- Assert reset low during RD_WAIT → all outputs 0 immediately; after release, no spurious io_ready; the next read completes normally.
